// File: rtl/tl_ul_client_master.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_client_master
// Purpose  : TileLink-UL client. Converts a simple command/response interface
//            into channel A requests (Get / PutFullData / PutPartialData) and
//            returns channel D responses. Up to MAX_OUTSTANDING transactions
//            are in flight, tracked by source ID. Responses may be out of order.
// Options  : TL_MASTER_TIMEOUT_EN adds a per-slot response watchdog that
//            drives timeout_err. Without the macro, timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_client_master #(
  parameter int ADDR_W          = 14,
  parameter int DATA_W          = 32,
  parameter int SRC_W           = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic                clock,
  input  logic                reset,
  // command interface
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_size,
  input  logic [DATA_W/8-1:0] cmd_mask,
  input  logic [DATA_W-1:0]   cmd_wdata,
  // response interface
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SRC_W-1:0]    rsp_id,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  // TL channel A
  output logic                a_valid,
  input  logic                a_ready,
  output logic [2:0]          a_opcode,
  output logic [2:0]          a_param,
  output logic [3:0]          a_size,
  output logic [SRC_W-1:0]    a_source,
  output logic [ADDR_W-1:0]   a_address,
  output logic [DATA_W/8-1:0] a_mask,
  output logic [DATA_W-1:0]   a_data,
  output logic                a_corrupt,
  // TL channel D
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [1:0]          d_param,
  input  logic [3:0]          d_size,
  input  logic [SRC_W-1:0]    d_source,
  input  logic                d_sink,
  input  logic                d_denied,
  input  logic [DATA_W-1:0]   d_data,
  input  logic                d_corrupt,
  // status
  output logic                busy,
  output logic                proto_err,
  output logic                timeout_err
);

  localparam int          c_MASK_W       = DATA_W / 8;
  localparam logic [3:0]  c_FULL_SIZE    = 4'($clog2(c_MASK_W));
  localparam logic [2:0]  c_OP_GET       = 3'd4;
  localparam logic [2:0]  c_OP_PUT_FULL  = 3'd0;
  localparam logic [2:0]  c_OP_PUT_PART  = 3'd1;
  localparam logic [2:0]  c_OP_ACK       = 3'd0;

  logic [MAX_OUTSTANDING-1:0] r_slot_busy;
  logic [MAX_OUTSTANDING-1:0] w_alloc;
  logic [MAX_OUTSTANDING-1:0] w_release;
  logic                       w_free_any;
  logic [SRC_W-1:0]           w_free_idx;
  logic                       w_d_hit;
  logic                       w_cmd_fire;
  logic                       w_d_fire;
  logic                       w_unused_d;

  // Sideband D fields carry nothing this client needs.
  assign w_unused_d = ^{d_param, d_sink, d_size};

  assign cmd_ready  = (!a_valid || a_ready) && w_free_any;
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign d_ready    = !rsp_valid || rsp_ready;
  assign w_d_fire   = d_valid && d_ready;
  assign busy       = a_valid || (|r_slot_busy);
  assign a_param    = 3'd0;
  assign a_corrupt  = 1'b0;

  // Lowest free slot index becomes the source ID of the next command.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_slot_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SRC_W'(i);
      end
    end
  end

  // One-hot allocate (from the pre-edge free vector) and release masks.
  always_comb begin
    w_alloc   = '0;
    w_release = '0;
    w_d_hit   = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_alloc[i] = w_cmd_fire && (w_free_idx == SRC_W'(i));
      if ((d_source == SRC_W'(i)) && r_slot_busy[i]) begin
        w_d_hit      = 1'b1;
        w_release[i] = w_d_fire;
      end
    end
  end

  // Slot occupancy: allocate and release never target the same slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_slot_busy <= '0;
    else       r_slot_busy <= (r_slot_busy & ~w_release) | w_alloc;
  end

  // Channel A holding register: load on command fire, drop on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_opcode  <= 3'd0;
      a_size    <= 4'd0;
      a_source  <= '0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
    end else if (w_cmd_fire) begin
      a_valid   <= 1'b1;
      if (!cmd_write)
        a_opcode <= c_OP_GET;
      else if ((&cmd_mask) && (cmd_size == c_FULL_SIZE))
        a_opcode <= c_OP_PUT_FULL;
      else
        a_opcode <= c_OP_PUT_PART;
      a_size    <= cmd_size;
      a_source  <= w_free_idx;
      a_address <= cmd_addr;
      a_mask    <= cmd_mask;
      a_data    <= cmd_write ? cmd_wdata : '0;
    end else if (a_ready) begin
      a_valid   <= 1'b0;
    end
  end

  // Single-entry response register loaded by a D beat for an allocated slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (w_d_fire && w_d_hit) begin
      rsp_valid <= 1'b1;
      rsp_id    <= d_source;
      rsp_write <= (d_opcode == c_OP_ACK);
      rsp_rdata <= d_data;
      rsp_error <= d_denied || d_corrupt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Sticky flag for D beats whose source has no transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    proto_err <= 1'b0;
    else if (w_d_fire && !w_d_hit) proto_err <= 1'b1;
  end

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  logic [MAX_OUTSTANDING-1:0] w_expire;

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot_timer
    logic [c_CNT_W-1:0] r_cnt;
    // Age of the slot's transaction, saturating at TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        r_cnt <= '0;
      else if (w_alloc[gi])
        r_cnt <= '0;
      else if (r_slot_busy[gi] && (r_cnt != c_CNT_W'(TIMEOUT)))
        r_cnt <= r_cnt + 1'b1;
    end
    // Flag rises on the edge where the age reaches TIMEOUT.
    assign w_expire[gi] = r_slot_busy[gi] && (r_cnt == c_CNT_W'(TIMEOUT - 1));
  end

  // Sticky watchdog flag; the expired slot stays busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           timeout_err <= 1'b0;
    else if (|w_expire)  timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_client_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_ul_client_master
// Purpose  : Directed bench for tl_ul_client_master with a transaction-level
//            reference model compared on every falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_ul_client_master;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int MO = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [3:0]    cmd_size = '0;
  logic [3:0]    cmd_mask = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_write, rsp_error;
  logic          rsp_ready = 1'b1;
  logic [SW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          a_valid, a_corrupt;
  logic          a_ready = 1'b1;
  logic [2:0]    a_opcode, a_param;
  logic [3:0]    a_size, a_mask;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;
  logic          d_valid = 1'b0, d_sink = 1'b0, d_denied = 1'b0, d_corrupt = 1'b0;
  logic          d_ready;
  logic [2:0]    d_opcode = '0;
  logic [1:0]    d_param = '0;
  logic [3:0]    d_size = 4'd2;
  logic [SW-1:0] d_source = '0;
  logic [DW-1:0] d_data = '0;
  logic          busy, proto_err, timeout_err;

  int checks = 0;
  int errors = 0;

  tl_ul_client_master #(
    .ADDR_W(AW), .DATA_W(DW), .SRC_W(SW), .MAX_OUTSTANDING(MO), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt),
    .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_slot [MO];
  int            m_age  [MO];
  logic          m_av, m_rv, m_rw, m_rerr, m_perr, m_terr;
  logic [2:0]    m_op;
  logic [SW-1:0] m_src, m_rid;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_size, m_mask;
  logic [DW-1:0] m_data, m_rdata;

  function automatic int lowest_free();
    for (int i = 0; i < MO; i++) if (!m_slot[i]) return i;
    return -1;
  endfunction

  function automatic logic exp_cmd_ready();
    return (!m_av || a_ready) && (lowest_free() >= 0);
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = m_av;
    for (int i = 0; i < MO; i++) b = b | m_slot[i];
    return b;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      for (int i = 0; i < MO; i++) begin m_slot[i] = 0; m_age[i] = 0; end
      m_av = 0; m_rv = 0; m_perr = 0; m_terr = 0;
      m_op = 0; m_src = 0; m_addr = 0; m_size = 0; m_mask = 0; m_data = 0;
      m_rid = 0; m_rw = 0; m_rdata = 0; m_rerr = 0;
    end else begin
      int  f, s;
      bit  cf, df, hit;
      bit  old [MO];
      f   = lowest_free();
      cf  = cmd_valid && exp_cmd_ready();
      df  = d_valid && (!m_rv || rsp_ready);
      old = m_slot;
`ifdef TL_MASTER_TIMEOUT_EN
      for (int i = 0; i < MO; i++) begin
        if (old[i] && m_age[i] < TO) begin
          m_age[i]++;
          if (m_age[i] == TO) m_terr = 1;
        end
      end
`endif
      if (cf) begin
        m_av   = 1;
        m_src  = SW'(f);
        m_addr = cmd_addr;
        m_size = cmd_size;
        m_mask = cmd_mask;
        m_data = cmd_write ? cmd_wdata : 0;
        m_op   = !cmd_write ? 3'd4 : ((cmd_mask == 4'hF && cmd_size == 4'd2) ? 3'd0 : 3'd1);
        m_slot[f] = 1;
        m_age[f]  = 0;
      end else if (a_ready) begin
        m_av = 0;
      end
      s   = int'(d_source);
      hit = (s < MO) ? old[s] : 0;
      if (df) begin
        if (hit) begin
          m_slot[s] = 0;
          m_rv = 1; m_rid = d_source; m_rw = (d_opcode == 3'd0);
          m_rdata = d_data; m_rerr = d_denied | d_corrupt;
        end else begin
          m_perr = 1;
        end
      end else if (rsp_ready) begin
        m_rv = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clock);
    chk("cmd_ready", cmd_ready, exp_cmd_ready());
    chk("d_ready", d_ready, !m_rv || rsp_ready);
    chk("a_valid", a_valid, m_av);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("busy", busy, exp_busy());
    chk("proto_err", proto_err, m_perr);
    chk("timeout_err", timeout_err, m_terr);
    if (m_av) begin
      chk("a_opcode", a_opcode, m_op);
      chk("a_param", a_param, 0);
      chk("a_corrupt", a_corrupt, 0);
      chk("a_source", a_source, m_src);
      chk("a_address", a_address, m_addr);
      chk("a_size", a_size, m_size);
      chk("a_mask", a_mask, m_mask);
      chk("a_data", a_data, m_data);
    end
    if (m_rv) begin
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_write", rsp_write, m_rw);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_error", rsp_error, m_rerr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] addr, input logic [3:0] sz,
                          input logic [3:0] mk, input logic [DW-1:0] wd);
    bit fired;
    fired = 0;
    cmd_write = w; cmd_addr = addr; cmd_size = sz; cmd_mask = mk; cmd_wdata = wd;
    cmd_valid = 1;
    for (int n = 0; n < 50 && !fired; n++) begin
      #1;
      fired = cmd_ready;
      tick();
    end
    cmd_valid = 0;
    if (!fired) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [SW-1:0] src, input logic [DW-1:0] data,
                        input logic den, input logic cor);
    bit fired;
    fired = 0;
    d_opcode = op; d_source = src; d_data = data; d_denied = den; d_corrupt = cor;
    d_valid = 1;
    for (int n = 0; n < 50 && !fired; n++) begin
      #1;
      fired = d_ready;
      tick();
    end
    d_valid = 0; d_denied = 0; d_corrupt = 0;
    if (!fired) chk("d_accept_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(); tick();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 0;
    tick();

    // Read
    send_cmd(0, 14'h0100, 4'd2, 4'hF, 32'h0);
    chk("rd_a_valid", a_valid, 1);
    chk("rd_a_opcode", a_opcode, 4);
    chk("rd_a_source", a_source, 0);
    chk("rd_a_address", a_address, 14'h0100);
    chk("rd_a_data", a_data, 0);
    tick();
    d_beat(3'd1, 5'd0, 32'hDEADBEEF, 0, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_id", rsp_id, 0);
    chk("rd_rsp_error", rsp_error, 0);
    chk("rd_rsp_write", rsp_write, 0);
    tick();

    // Writes
    send_cmd(1, 14'h0204, 4'd2, 4'hF, 32'h11223344);
    chk("wf_a_opcode", a_opcode, 0);
    chk("wf_a_data", a_data, 32'h11223344);
    tick();
    send_cmd(1, 14'h0206, 4'd1, 4'h3, 32'h0000AABB);
    chk("wp_a_opcode", a_opcode, 1);
    chk("wp_a_source", a_source, 1);
    chk("wp_a_mask", a_mask, 4'h3);
    tick();
    d_beat(3'd0, 5'd0, 32'h0, 1, 0);
    chk("wd_rsp_write", rsp_write, 1);
    chk("wd_rsp_error", rsp_error, 1);
    d_beat(3'd0, 5'd1, 32'h0, 0, 0);
    chk("wp_rsp_id", rsp_id, 1);
    chk("wp_rsp_error", rsp_error, 0);
    tick();

    // Outstanding limit and out-of-order return
    for (int i = 0; i < MO; i++) begin
      send_cmd(0, AW'(14'h0010 + i * 4), 4'd2, 4'hF, 32'h0);
      chk("lim_a_source", a_source, i);
    end
    chk("lim_cmd_ready", cmd_ready, 0);
    cmd_valid = 1;
    tick(); tick();
    chk("lim_still_blocked", cmd_ready, 0);
    cmd_valid = 0;
    d_beat(3'd1, 5'd2, 32'h00000222, 0, 0);
    chk("ooo_rsp_id", rsp_id, 2);
    chk("ooo_cmd_ready", cmd_ready, 1);
    send_cmd(0, 14'h0040, 4'd2, 4'hF, 32'h0);
    chk("ooo_reuse_source", a_source, 2);
    d_beat(3'd1, 5'd3, 32'h3, 0, 0);
    d_beat(3'd1, 5'd0, 32'h0, 0, 0);
    d_beat(3'd1, 5'd1, 32'h1, 0, 1);
    chk("cor_rsp_error", rsp_error, 1);
    d_beat(3'd1, 5'd2, 32'h2, 0, 0);
    tick();

    // A backpressure
    a_ready = 0;
    send_cmd(1, 14'h0300, 4'd2, 4'hF, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      chk("bp_a_valid", a_valid, 1);
      chk("bp_a_address", a_address, 14'h0300);
      chk("bp_a_data", a_data, 32'hCAFEF00D);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    a_ready = 1;
    tick();

    // D / response backpressure
    rsp_ready = 0;
    send_cmd(0, 14'h0304, 4'd2, 4'hF, 32'h0);
    chk("rb_a_source", a_source, 1);
    tick();
    d_beat(3'd0, 5'd0, 32'h0, 0, 0);
    chk("rb_rsp_valid", rsp_valid, 1);
    chk("rb_d_ready", d_ready, 0);
    d_opcode = 3'd1; d_source = 5'd1; d_data = 32'h55; d_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_hold_d_ready", d_ready, 0);
      chk("rb_hold_rsp_id", rsp_id, 0);
    end
    rsp_ready = 1;
    #1;
    chk("rb_release_d_ready", d_ready, 1);
    tick();
    d_valid = 0;
    chk("rb_rsp_id2", rsp_id, 1);
    chk("rb_rsp_rdata2", rsp_rdata, 32'h55);
    tick();

    // Protocol error
    d_beat(3'd1, 5'd3, 32'h0, 0, 0);
    chk("pe_proto_err", proto_err, 1);
    chk("pe_rsp_valid", rsp_valid, 0);
    tick();

    // Reset mid-flight, then stray D beat
    send_cmd(0, 14'h0400, 4'd2, 4'hF, 32'h0);
    send_cmd(0, 14'h0404, 4'd2, 4'hF, 32'h0);
    reset = 1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_a_valid", a_valid, 0);
    chk("mr_proto_err", proto_err, 0);
    tick();
    reset = 0;
    tick();
    d_beat(3'd1, 5'd0, 32'h0, 0, 0);
    chk("stray_proto_err", proto_err, 1);
    chk("stray_rsp_valid", rsp_valid, 0);

    // Watchdog
    reset = 1;
    tick();
    reset = 0;
    tick();
    send_cmd(0, 14'h0500, 4'd2, 4'hF, 32'h0);
`ifdef TL_MASTER_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("to_before", timeout_err, 0);
    tick();
    chk("to_after", timeout_err, 1);
`else
    repeat (TO + 4) tick();
    chk("to_disabled", timeout_err, 0);
`endif
    d_beat(3'd1, 5'd0, 32'h0, 0, 0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
